vehicle_dynamics: RTL and testbench
===================================

VEHICLE_DYNAMICS -- requirements
Module: vehicle_dynamics

Interface
REQ-001 Parameters SHALL be (name, default, meaning):
- NUM_GEARS, 6, forward gears in D (2..7).
- UP_STEP, 30, km/h per gear band.
- HYST, 5, downshift hysteresis in km/h.
- SHIFT_HOLD, 4, tick_speed pulses per shift.
- IDLE_RPM, 800, idle rpm.
- MAX_RPM, 7000, rpm clamp.
- RPM_SLOPE, 100, rpm per km/h inside a gear band.
- ESS_SPEED, 50, hard-brake ESS speed threshold.
REQ-002 Ports SHALL be (name, direction, width, meaning):
- clk, in, 1, single clock, all state on its rising edge.
- rst_n, in, 1, reset: asynchronous, active-low.
- tick_1sec, in, 1, one-cycle 1 Hz strobe.
- tick_speed, in, 1, one-cycle speed-update strobe.
- current_gear, in, 4, selector: 3=P, 6=R, 9=N, 12=D; any other code is treated as N.
- adc_accel, in, 8, pedal position.
- is_brake_normal, in, 1, normal brake.
- is_brake_hard, in, 1, hard brake.
- speed, out, 8, km/h.
- rpm, out, 14, engine rpm, registered.
- gear_num, out, 3, 0 outside D, otherwise 1..NUM_GEARS.
- shifting, out, 1, shift in progress.
- fuel, out, 8, fuel level.
- temp, out, 8, coolant temperature.
- odometer_raw, out, 32, accumulated speed.
- ess_trigger, out, 1, emergency stop signal.

Function
REQ-003 Speed SHALL update only on tick_speed, with saturation at 0 and 255.
- Priority order: hard brake -10, then normal brake -2, then accel (adc_accel>10) +(1+adc_accel[7:6]), then coast -1.
- Brake and accel updates apply only in D or R; in P/N speed always coasts -1.
REQ-004 Effective accel SHALL be treated as 0 while shifting=1; braking and coast are unaffected.
REQ-005 The shift FSM SHALL have states OFF, DRIVE, UP, DOWN.
- OFF: gear_num=0; enters DRIVE with gear_num=1 on the cycle after current_gear becomes 12.
REQ-006 In DRIVE, on tick_speed:
- Go to UP if gear_num<NUM_GEARS and speed>=gear_num*UP_STEP.
- Otherwise go to DOWN if gear_num>1 and speed<(gear_num-1)*UP_STEP-HYST.
- Upshift is tested first.
REQ-007 UP/DOWN SHALL hold shifting=1 and count SHIFT_HOLD tick_speed pulses, then increment or decrement gear_num and return to DRIVE, at most one gear step per shift.
REQ-008 A current_gear change away from 12 SHALL force OFF from any state on the next clock, clear shifting and the shift counter, and set gear_num=0.
REQ-009 rpm SHALL be registered with one-clk latency from its inputs:
- P/N: IDLE_RPM+adc_accel*20.
- R: IDLE_RPM+speed*60.
- D: IDLE_RPM+(speed-(gear_num-1)*UP_STEP)*RPM_SLOPE; a negative band offset is treated as 0; the result is clamped to MAX_RPM.
- OFF state within D: IDLE_RPM.
- All intermediate arithmetic is 20-bit unsigned.
REQ-010 ess_trigger SHALL set on a tick_speed where is_brake_hard=1 and pre-update speed>ESS_SPEED in D/R.
- It holds until speed reaches 0 or effective accel is applied, whichever comes first.
REQ-011 On tick_1sec:
- odometer_raw += speed, using pre-update speed when tick_speed coincides; wraps modulo 2^32.
- fuel decrements by 2 if rpm>4000, else by 1 if speed>0 or rpm>1000; saturates at 0.
- temp +2 if rpm>3000 and temp<200, else -1 if temp>50.
REQ-012 tick_1sec and tick_speed in the same cycle SHALL both be processed.

Reset
REQ-013 While rst_n=0, all outputs SHALL take their reset values: speed=0, rpm=IDLE_RPM, gear_num=0, shifting=0, fuel=100, temp=50, odometer_raw=0, ess_trigger=0, FSM=OFF, shift counter=0.
- Assertion mid-shift aborts the shift with no gear change.

Configuration
REQ-014 With macro VEHICLE_FUEL_STARVE_EN defined, fuel==0 SHALL force effective accel to 0 and hold rpm at IDLE_RPM in all selector positions.
- Without the macro, fuel saturates at 0 with no effect on accel or rpm.

Verification
REQ-015 Bench SHALL cover:
- D, adc_accel=200, 30 tick_speed: speed +4 per tick, except no increase on the 4 shift ticks; gear_num 1->2 at speed>=30 after 4 ticks with shifting=1.
- D gear 2 at speed 26, coast: no downshift until speed<25; then DOWN, gear_num=1 after 4 ticks.
- D speed 60, is_brake_hard 1 tick: speed=50, ess_trigger=1; held through coast until speed=0.
- Mid-UP, current_gear->9: next clk FSM=OFF, gear_num=0, shifting=0; rpm=800+adc_accel*20 one clk later.
- tick_1sec+tick_speed same cycle at speed 40, accel: odometer +40, speed 41+.
- fuel=1, rpm=4500, tick_1sec: fuel=0; with VEHICLE_FUEL_STARVE_EN, accel is ignored and rpm=800.

Source files
------------

// File: rtl/vehicle_dynamics.sv
// vehicle_dynamics: speed, shift FSM, rpm, fuel, temperature, odometer and ESS for a simple vehicle.
// Optional macro VEHICLE_FUEL_STARVE_EN: an empty tank cuts accel and pins rpm at idle.
module vehicle_dynamics #(
    parameter int NUM_GEARS  = 6,
    parameter int UP_STEP    = 30,
    parameter int HYST       = 5,
    parameter int SHIFT_HOLD = 4,
    parameter int IDLE_RPM   = 800,
    parameter int MAX_RPM    = 7000,
    parameter int RPM_SLOPE  = 100,
    parameter int ESS_SPEED  = 50
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        tick_1sec,
    input  logic        tick_speed,
    input  logic [3:0]  current_gear,
    input  logic [7:0]  adc_accel,
    input  logic        is_brake_normal,
    input  logic        is_brake_hard,
    output logic [7:0]  speed,
    output logic [13:0] rpm,
    output logic [2:0]  gear_num,
    output logic        shifting,
    output logic [7:0]  fuel,
    output logic [7:0]  temp,
    output logic [31:0] odometer_raw,
    output logic        ess_trigger
);
    typedef enum logic [1:0] {OFF, DRIVE, UP, DOWN} state_t;
    localparam logic [19:0] UP20    = 20'(UP_STEP);
    localparam logic [19:0] HYST20  = 20'(HYST);
    localparam logic [19:0] IDLE20  = 20'(IDLE_RPM);
    localparam logic [19:0] MAX20   = 20'(MAX_RPM);
    localparam logic [19:0] SLOPE20 = 20'(RPM_SLOPE);
    localparam logic [2:0]  NG3     = 3'(NUM_GEARS);
    localparam logic [7:0]  HOLD_LAST = 8'(SHIFT_HOLD - 1);
    localparam logic [7:0]  ESS8    = 8'(ESS_SPEED);

    state_t state, state_nxt;
    logic [7:0]  cnt, speed_nxt;
    logic [8:0]  accel_sum;
    logic [19:0] s20, g20, band_base, band, rpm_d, rpm_nxt;
    logic [1:0]  fuel_dec;
    logic in_d, in_r, drv, starve, accel_on, accel_applied, up_go, dn_go, shift_done, ess_set;

    assign in_d = current_gear == 4'd12;
    assign in_r = current_gear == 4'd6;
    assign drv  = in_d || in_r;
`ifdef VEHICLE_FUEL_STARVE_EN
    assign starve = fuel == 8'd0;
`else
    assign starve = 1'b0;
`endif
    assign accel_on      = drv && adc_accel > 8'd10 && !shifting && !starve;
    assign accel_applied = tick_speed && accel_on && !is_brake_hard && !is_brake_normal;
    assign accel_sum     = {1'b0, speed} + 9'd1 + {7'd0, adc_accel[7:6]};
    // Brake and accel only act in D/R; P/N (and unknown codes) always coast.
    assign speed_nxt = !tick_speed ? speed
                     : drv && is_brake_hard   ? (speed > 8'd10 ? speed - 8'd10 : 8'd0)
                     : drv && is_brake_normal ? (speed > 8'd2 ? speed - 8'd2 : 8'd0)
                     : accel_on ? (accel_sum[8] ? 8'd255 : accel_sum[7:0])
                     : speed != 8'd0 ? speed - 8'd1 : 8'd0;
    assign ess_set = tick_speed && drv && is_brake_hard && speed > ESS8;

    assign s20        = {12'd0, speed};
    assign g20        = {17'd0, gear_num};
    assign band_base  = (g20 - 20'd1) * UP20;
    assign up_go      = gear_num < NG3 && s20 >= g20 * UP20;
    assign dn_go      = gear_num > 3'd1 && s20 < band_base - HYST20;
    assign shift_done = shifting && tick_speed && cnt == HOLD_LAST;

    assign band    = s20 > band_base ? s20 - band_base : 20'd0;
    assign rpm_d   = IDLE20 + band * SLOPE20;
    assign rpm_nxt = starve ? IDLE20
                   : in_d ? (state == OFF ? IDLE20 : rpm_d > MAX20 ? MAX20 : rpm_d)
                   : in_r ? IDLE20 + s20 * 20'd60
                   : IDLE20 + {12'd0, adc_accel} * 20'd20;
    assign fuel_dec = rpm > 14'd4000 ? 2'd2 : (speed != 8'd0 || rpm > 14'd1000) ? 2'd1 : 2'd0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= OFF;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = !in_d ? OFF
                  : state == OFF ? DRIVE
                  : state == DRIVE ? (tick_speed && up_go ? UP : tick_speed && dn_go ? DOWN : DRIVE)
                  : shift_done ? DRIVE : state;
    end

    always_comb begin
        shifting = state == UP || state == DOWN;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            speed        <= 8'd0;
            rpm          <= 14'(IDLE_RPM);
            gear_num     <= 3'd0;
            cnt          <= 8'd0;
            fuel         <= 8'd100;
            temp         <= 8'd50;
            odometer_raw <= 32'd0;
            ess_trigger  <= 1'b0;
        end else begin
            speed        <= speed_nxt;
            rpm          <= 14'(rpm_nxt);
            gear_num     <= !in_d ? 3'd0 : state == OFF ? 3'd1
                          : shift_done ? (state == UP ? gear_num + 3'd1 : gear_num - 3'd1) : gear_num;
            cnt          <= (!in_d || !shifting || shift_done) ? 8'd0 : tick_speed ? cnt + 8'd1 : cnt;
            fuel         <= !tick_1sec ? fuel : fuel > {6'd0, fuel_dec} ? fuel - {6'd0, fuel_dec} : 8'd0;
            temp         <= !tick_1sec ? temp : (rpm > 14'd3000 && temp < 8'd200) ? temp + 8'd2
                          : temp > 8'd50 ? temp - 8'd1 : temp;
            odometer_raw <= tick_1sec ? odometer_raw + {24'd0, speed} : odometer_raw;
            ess_trigger  <= ess_set || (ess_trigger && !accel_applied && speed_nxt != 8'd0);
        end
    end
endmodule

// File: tb/tb_vehicle_dynamics.sv
// tb_vehicle_dynamics: directed vectors with hand-computed expectations for vehicle_dynamics.
module tb_vehicle_dynamics;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        tick_1sec = 1'b0;
    logic        tick_speed = 1'b0;
    logic [3:0]  current_gear = 4'd9;
    logic [7:0]  adc_accel = 8'd0;
    logic        is_brake_normal = 1'b0;
    logic        is_brake_hard = 1'b0;
    logic [7:0]  speed;
    logic [13:0] rpm;
    logic [2:0]  gear_num;
    logic        shifting;
    logic [7:0]  fuel;
    logic [7:0]  temp;
    logic [31:0] odometer_raw;
    logic        ess_trigger;
    int checks = 0;
    int failures = 0;

    vehicle_dynamics dut (
        .clk(clk), .rst_n(rst_n), .tick_1sec(tick_1sec), .tick_speed(tick_speed),
        .current_gear(current_gear), .adc_accel(adc_accel),
        .is_brake_normal(is_brake_normal), .is_brake_hard(is_brake_hard),
        .speed(speed), .rpm(rpm), .gear_num(gear_num), .shifting(shifting),
        .fuel(fuel), .temp(temp), .odometer_raw(odometer_raw), .ess_trigger(ess_trigger)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic tick_sp(input int n);
        repeat (n) begin
            tick_speed = 1'b1;
            @(posedge clk);
            #1;
            tick_speed = 1'b0;
        end
    endtask

    task automatic tick_s(input int n);
        repeat (n) begin
            tick_1sec = 1'b1;
            @(posedge clk);
            #1;
            tick_1sec = 1'b0;
        end
    endtask

    initial begin
        cyc(2);
        check("rst_speed", speed, 0);
        check("rst_rpm", rpm, 800);
        check("rst_gear", gear_num, 0);
        check("rst_shifting", shifting, 0);
        check("rst_fuel", fuel, 100);
        check("rst_temp", temp, 50);
        check("rst_odo", odometer_raw, 0);
        check("rst_ess", ess_trigger, 0);
        rst_n = 1'b1;
        cyc(1);
        // Launch in D at full pedal (+4 per tick)
        current_gear = 4'd12;
        cyc(1);
        check("d_enter_gear", gear_num, 1);
        adc_accel = 8'd200;
        tick_sp(8);
        check("up_t8_speed", speed, 32);
        check("up_t8_shift", shifting, 0);
        tick_sp(1);
        check("up_t9_speed", speed, 36);
        check("up_t9_shift", shifting, 1);
        check("up_t9_gear", gear_num, 1);
        tick_sp(3);
        check("up_t12_speed", speed, 33);
        check("up_t12_gear", gear_num, 1);
        tick_sp(1);
        check("up_t13_speed", speed, 32);
        check("up_t13_gear", gear_num, 2);
        check("up_t13_shift", shifting, 0);
        tick_sp(1);
        check("up_t14_speed", speed, 36);
        cyc(1);
        check("rpm_g2_36", rpm, 1400);
        tick_sp(16);
        check("up_t30_speed", speed, 80);
        check("up_t30_gear", gear_num, 3);
        cyc(1);
        check("rpm_g3_80", rpm, 2800);
        // Coast down to gear 2 at 26 km/h, then hysteresis edge
        adc_accel = 8'd0;
        tick_sp(54);
        check("dn_26_speed", speed, 26);
        check("dn_26_gear", gear_num, 2);
        check("dn_26_shift", shifting, 0);
        tick_sp(2);
        check("dn_24_speed", speed, 24);
        check("dn_24_shift", shifting, 0);
        tick_sp(1);
        check("dn_23_speed", speed, 23);
        check("dn_23_shift", shifting, 1);
        check("dn_23_gear", gear_num, 2);
        cyc(1);
        check("rpm_neg_band", rpm, 800);
        tick_sp(3);
        check("dn_20_gear", gear_num, 2);
        tick_sp(1);
        check("dn_19_speed", speed, 19);
        check("dn_19_gear", gear_num, 1);
        check("dn_19_shift", shifting, 0);
        // Reverse build-up, D clamp, then hard brake / ESS
        current_gear = 4'd6;
        tick_sp(1);
        check("r_off_gear", gear_num, 0);
        adc_accel = 8'd200;
        tick_sp(14);
        cyc(1);
        check("r_speed", speed, 74);
        check("r_rpm", rpm, 5240);
        current_gear = 4'd12;
        cyc(1);
        check("d_off_rpm", rpm, 800);
        cyc(1);
        check("d_clamp_rpm", rpm, 7000);
        adc_accel = 8'd0;
        is_brake_normal = 1'b1;
        tick_sp(7);
        is_brake_normal = 1'b0;
        check("brake_n_speed", speed, 60);
        check("brake_n_ess", ess_trigger, 0);
        is_brake_hard = 1'b1;
        tick_sp(1);
        is_brake_hard = 1'b0;
        check("brake_h_speed", speed, 50);
        check("ess_set", ess_trigger, 1);
        tick_sp(49);
        check("ess_hold_speed", speed, 1);
        check("ess_hold", ess_trigger, 1);
        tick_sp(1);
        check("ess_clr_speed", speed, 0);
        check("ess_clr", ess_trigger, 0);
        tick_sp(1);
        check("speed_floor", speed, 0);
        // Mid-UP selector change to N
        current_gear = 4'd6;
        adc_accel = 8'd200;
        tick_sp(10);
        check("r40_speed", speed, 40);
        current_gear = 4'd12;
        cyc(1);
        tick_sp(1);
        check("midup_shift", shifting, 1);
        check("midup_speed", speed, 44);
        current_gear = 4'd9;
        cyc(1);
        check("abort_gear", gear_num, 0);
        check("abort_shift", shifting, 0);
        cyc(1);
        check("abort_rpm", rpm, 4800);
        // Coincident 1 s and speed ticks at 40 km/h
        current_gear = 4'd6;
        adc_accel = 8'd0;
        tick_sp(4);
        cyc(1);
        adc_accel = 8'd200;
        tick_speed = 1'b1;
        tick_1sec = 1'b1;
        @(posedge clk);
        #1;
        tick_speed = 1'b0;
        tick_1sec = 1'b0;
        check("both_odo", odometer_raw, 40);
        check("both_speed", speed, 44);
        check("both_fuel", fuel, 99);
        check("both_temp", temp, 52);
        // Drain fuel at 4500 rpm in N
        current_gear = 4'd9;
        adc_accel = 8'd185;
        cyc(1);
        check("n_rpm_4500", rpm, 4500);
        tick_s(49);
        check("drain_fuel1", fuel, 1);
        check("drain_temp", temp, 150);
        check("drain_odo", odometer_raw, 2196);
        tick_s(1);
        check("fuel_zero", fuel, 0);
        check("temp_152", temp, 152);
        tick_s(1);
        check("fuel_sat", fuel, 0);
        cyc(1);
        current_gear = 4'd6;
        adc_accel = 8'd200;
`ifdef VEHICLE_FUEL_STARVE_EN
        check("starve_rpm", rpm, 800);
        tick_sp(1);
        check("starve_speed", speed, 43);
`else
        check("empty_rpm", rpm, 4500);
        tick_sp(1);
        check("empty_speed", speed, 48);
`endif
        // Reset asserted mid-shift
        current_gear = 4'd12;
        cyc(1);
        tick_sp(1);
        check("pre_rst_shift", shifting, 1);
        rst_n = 1'b0;
        #1;
        check("async_rst_gear", gear_num, 0);
        check("async_rst_shift", shifting, 0);
        check("async_rst_fuel", fuel, 100);
        cyc(1);
        rst_n = 1'b1;
        cyc(1);
        check("post_rst_gear", gear_num, 1);
        check("post_rst_shift", shifting, 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
